decoder_stream: RTL and testbench

DECODER_STREAM -- requirements
Module: decoder_stream

---
 rtl/decoder_pkg.sv | 13 +
 rtl/decoder_core.sv | 26 ++
 rtl/decoder_stream.sv | 143 ++++++++++++++
 tb/tb_decoder_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared FSM state type and output polarity constants for decoder_stream
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    localparam int POL_ACTIVE_HIGH = 0;
    localparam int POL_ACTIVE_LOW  = 1;

endpackage

// File: rtl/decoder_core.sv
// rtl/decoder_core.sv - combinational code to one-hot decode with selectable polarity
module decoder_core
    import decoder_pkg::*;
#(
    parameter int CODE_W     = 3,
    parameter int NUM_OUT    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic [CODE_W-1:0]  code_i,
    output logic [NUM_OUT-1:0] onehot_o
);

    // Codes at or beyond NUM_OUT match no bit, so they decode to all-inactive.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(code_i) == i) begin
                onehot_o[i] = 1'b1;
            end
        end
        if (ACTIVE_LOW == POL_ACTIVE_LOW) begin
            onehot_o = ~onehot_o;
        end
    end

endmodule

// File: rtl/decoder_stream.sv
// rtl/decoder_stream.sv - handshaked one-hot decoder with automatic code sweep; DECODER_RANGE_CHECK_EN enables err on out-of-range codes
module decoder_stream
    import decoder_pkg::*;
#(
    parameter int CODE_W     = 3,
    parameter int NUM_OUT    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  code,
    input  logic               scan_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] q,
    output logic               err,
    output logic               busy
);

    localparam logic [NUM_OUT-1:0] Q_IDLE    = (ACTIVE_LOW == POL_ACTIVE_LOW) ? '1 : '0;
    localparam logic [CODE_W-1:0]  SCAN_LAST = CODE_W'(NUM_OUT - 1);

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  cnt_q, cnt_d;
    logic [NUM_OUT-1:0] q_q, q_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;

    logic [CODE_W-1:0]  dec_code;
    logic [NUM_OUT-1:0] dec_q;
    logic               code_err;

`ifdef DECODER_RANGE_CHECK_EN
    assign code_err = (int'(code) >= NUM_OUT);
`else
    assign code_err = 1'b0;
`endif

    // The single decoder sees either the request code or the next sweep code.
    always_comb begin
        dec_code = code;
        if (state_q == ST_IDLE && scan_start) begin
            dec_code = '0;
        end else if (state_q == ST_SCAN) begin
            dec_code = cnt_q + CODE_W'(1);
        end
    end

    decoder_core #(
        .CODE_W     (CODE_W),
        .NUM_OUT    (NUM_OUT),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .code_i   (dec_code),
        .onehot_o (dec_q)
    );

    // Next-state and handshake logic; beats load the output register directly.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~scan_start;
                if (scan_start) begin
                    state_d     = ST_SCAN;
                    cnt_d       = '0;
                    q_d         = dec_q;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                end else if (in_valid) begin
                    state_d     = ST_HOLD;
                    q_d         = dec_q;
                    err_d       = code_err;
                    out_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        q_d   = dec_q;
                        err_d = code_err;
                    end else begin
                        state_d     = ST_IDLE;
                        q_d         = Q_IDLE;
                        err_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    if (cnt_q == SCAN_LAST) begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        q_d         = Q_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CODE_W'(1);
                        q_d   = dec_q;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                q_d         = Q_IDLE;
                err_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            q_q         <= Q_IDLE;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign q         = q_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_decoder_stream.sv
// tb/tb_decoder_stream.sv - directed self-checking bench for decoder_stream (CODE_W=3, NUM_OUT=6, both polarities)
module tb_decoder_stream;

`ifdef DECODER_RANGE_CHECK_EN
    localparam logic EXP_RANGE_ERR = 1'b1;
`else
    localparam logic EXP_RANGE_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] code = 3'd0;
    logic       scan_start = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_h, out_valid_h, err_h, busy_h;
    logic [5:0] q_h;
    logic       in_ready_l, out_valid_l, err_l, busy_l;
    logic [5:0] q_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_stream #(.CODE_W(3), .NUM_OUT(6), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .code(code),
        .scan_start(scan_start), .out_valid(out_valid_h), .out_ready(out_ready),
        .q(q_h), .err(err_h), .busy(busy_h)
    );

    decoder_stream #(.CODE_W(3), .NUM_OUT(6), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .code(code),
        .scan_start(scan_start), .out_valid(out_valid_l), .out_ready(out_ready),
        .q(q_l), .err(err_l), .busy(busy_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {out_valid, q, err, busy}
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; scan_start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({out_valid_h, q_h, err_h, busy_h} !== 9'b0_000000_0_0) begin
            failures++;
            $display("FAIL reset_hi got=%b exp=%b", {out_valid_h, q_h, err_h, busy_h}, 9'b0_000000_0_0);
        end
        checks++;
        if ({out_valid_l, q_l, err_l, busy_l} !== 9'b0_111111_0_0) begin
            failures++;
            $display("FAIL reset_lo got=%b exp=%b", {out_valid_l, q_l, err_l, busy_l}, 9'b0_111111_0_0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_h !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready_h);
        end
    endtask

    task automatic test_single();
        code = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid_h, q_h, err_h, busy_h} !== 9'b1_001000_0_0) begin
            failures++;
            $display("FAIL single_beat got=%b exp=%b", {out_valid_h, q_h, err_h, busy_h}, 9'b1_001000_0_0);
        end
        checks++;
        if (q_l !== 6'b110111) begin
            failures++;
            $display("FAIL single_beat_lo got=%b exp=110111", q_l);
        end
        tick();
        checks++;
        if ({out_valid_h, in_ready_h, q_h} !== 8'b0_1_000000) begin
            failures++;
            $display("FAIL single_idle got=%b exp=%b", {out_valid_h, in_ready_h, q_h}, 8'b0_1_000000);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [3] = '{3'd0, 3'd5, 3'd2};
        logic [5:0] exps  [3] = '{6'b000001, 6'b100000, 6'b000100};
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            code = codes[i];
            tick();
            checks++;
            if ({out_valid_h, q_h, err_h} !== {1'b1, exps[i], 1'b0}) begin
                failures++;
                $display("FAIL b2b_beat%0d got=%b exp=%b", i, {out_valid_h, q_h, err_h}, {1'b1, exps[i], 1'b0});
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid_h !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b exp=0", out_valid_h);
        end
    endtask

    task automatic test_stall();
        code = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b1; code = 3'd1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({out_valid_h, q_h, in_ready_h} !== 8'b1_010000_0) begin
                failures++;
                $display("FAIL stall_cycle%0d got=%b exp=%b", i, {out_valid_h, q_h, in_ready_h}, 8'b1_010000_0);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid_h, q_h, in_ready_h} !== 8'b1_010000_1) begin
            failures++;
            $display("FAIL stall_release got=%b exp=%b", {out_valid_h, q_h, in_ready_h}, 8'b1_010000_1);
        end
        tick();
        checks++;
        if (out_valid_h !== 1'b0) begin
            failures++;
            $display("FAIL stall_done got=%b exp=0", out_valid_h);
        end
    endtask

    task automatic test_scan();
        int k = 0;
        int n = 0;
        logic rdy = 1'b1;
        logic [5:0] e;
        scan_start = 1'b1; in_valid = 1'b1; code = 3'd3; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready_h !== 1'b0) begin
            failures++;
            $display("FAIL scan_wins_in_ready got=%b exp=0", in_ready_h);
        end
        tick();
        scan_start = 1'b0; in_valid = 1'b0;
        while (k < 6 && n < 40) begin
            e = 6'b000001 << k;
            checks++;
            if ({out_valid_h, q_h, err_h, busy_h} !== {1'b1, e, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL scan_beat%0d_cyc%0d got=%b exp=%b", k, n, {out_valid_h, q_h, err_h, busy_h}, {1'b1, e, 1'b0, 1'b1});
            end
            out_ready = rdy;
            scan_start = (n == 3);
            #1;
            checks++;
            if (in_ready_h !== 1'b0) begin
                failures++;
                $display("FAIL scan_in_ready_cyc%0d got=%b exp=0", n, in_ready_h);
            end
            tick();
            if (rdy) k++;
            rdy = ~rdy;
            n++;
        end
        scan_start = 1'b0;
        #1;
        checks++;
        if (k != 6) begin
            failures++;
            $display("FAIL scan_timeout got=%0d exp=6", k);
        end
        checks++;
        if ({out_valid_h, busy_h, in_ready_h} !== 3'b0_0_1) begin
            failures++;
            $display("FAIL scan_end got=%b exp=001", {out_valid_h, busy_h, in_ready_h});
        end
    endtask

    task automatic test_range();
        out_ready = 1'b1; in_valid = 1'b1;
        code = 3'd7;
        tick();
        checks++;
        if ({out_valid_h, q_h, err_h} !== {1'b1, 6'b000000, EXP_RANGE_ERR}) begin
            failures++;
            $display("FAIL range_code7 got=%b exp=%b", {out_valid_h, q_h, err_h}, {1'b1, 6'b000000, EXP_RANGE_ERR});
        end
        code = 3'd6;
        tick();
        checks++;
        if ({out_valid_h, q_l, err_l} !== {1'b1, 6'b111111, EXP_RANGE_ERR}) begin
            failures++;
            $display("FAIL range_code6 got=%b exp=%b", {out_valid_h, q_l, err_l}, {1'b1, 6'b111111, EXP_RANGE_ERR});
        end
        code = 3'd5;
        tick();
        checks++;
        if ({out_valid_h, q_h, err_h} !== 8'b1_100000_0) begin
            failures++;
            $display("FAIL range_code5 got=%b exp=%b", {out_valid_h, q_h, err_h}, 8'b1_100000_0);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        out_ready = 1'b1; scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid_l, q_l, busy_l} !== 8'b1_111011_1) begin
            failures++;
            $display("FAIL midscan_beat2 got=%b exp=%b", {out_valid_l, q_l, busy_l}, 8'b1_111011_1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid_l, q_l, busy_l, err_l} !== 9'b0_111111_0_0) begin
            failures++;
            $display("FAIL midscan_reset got=%b exp=%b", {out_valid_l, q_l, busy_l, err_l}, 9'b0_111111_0_0);
        end
        tick();
        checks++;
        if ({out_valid_l, busy_l, out_valid_h, busy_h} !== 4'b0000) begin
            failures++;
            $display("FAIL midscan_no_resume got=%b exp=0000", {out_valid_l, busy_l, out_valid_h, busy_h});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_scan();
        test_range();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
